// File: rtl/console_bridge.sv
// Memory-mapped console bridge: queues CPU console bytes in a FIFO and forwards
// them to the io sink at a paced rate. A power-off request waits until the FIFO is empty.
module console_bridge #(
  parameter int DEPTH     = 8,
  parameter int DRAIN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  cpu_address,
  input  logic [31:0] cpu_data_in,
  input  logic        cpu_write_enable,
  output logic [31:0] cpu_data_out,
  output logic        cpu_stall,
  output logic [31:0] io_memory_in,
  output logic [2:2]  io_address,
  output logic        io_write_enable
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int PACE_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(DRAIN_DIV - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_OFF} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [PACE_W-1:0]  pace_cnt;
  logic               full, empty, slot;
  logic               wr_out, wr_pwr;
  logic               push, pop, pwr_pulse;
  logic               unused_data;

  assign unused_data = ^cpu_data_in[31:8];
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign slot   = (pace_cnt == '0);
  assign wr_out = cpu_write_enable && (cpu_address == 2'd0);
  assign wr_pwr = cpu_write_enable && (cpu_address == 2'd1);

  // Decode against registered state only, so stall never depends on a same-cycle pop.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pop       = 1'b0;
    pwr_pulse = 1'b0;
    cpu_stall = 1'b0;
    case (state_q)
      ST_RUN: begin
        pop       = slot && !empty;
        push      = wr_out && !full;
        cpu_stall = wr_out && full;
        if (wr_pwr) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        pop = slot && !empty;
        if (slot && empty) begin
          pwr_pulse = 1'b1;
          state_d   = ST_OFF;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_data_out = '0;
    if (cpu_address == 2'd2)
      cpu_data_out = {16'b0, 8'(count), 5'b0, state_q == ST_OFF, full, empty};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FIFO storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cpu_data_in[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      pace_cnt        <= '0;
      io_write_enable <= 1'b0;
      io_address      <= 1'b0;
      io_memory_in    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (pop || pwr_pulse) pace_cnt <= PACE_RELOAD;
      else if (!slot)       pace_cnt <= pace_cnt - 1'b1;

      io_write_enable <= pop || pwr_pulse;
      if (pop) begin
        io_address   <= 1'b0;
        io_memory_in <= {24'b0, mem[rd_ptr]};
      end else if (pwr_pulse) begin
        io_address   <= 1'b1;
        io_memory_in <= '0;
      end
    end
  end
endmodule

// File: tb/tb_console_bridge.sv
// Bench for console_bridge: directed scenarios plus random traffic, checked each
// cycle against a queue-and-timestamp model of the console behaviour.
module tb_console_bridge;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_OFF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:2]  cpu_address = '0;
  logic [31:0] cpu_data_in = '0;
  logic        cpu_write_enable = 1'b0;
  logic [31:0] cpu_data_out;
  logic        cpu_stall;
  logic [31:0] io_memory_in;
  logic [2:2]  io_address;
  logic        io_write_enable;

  console_bridge #(.DEPTH(DEPTH), .DRAIN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_write_enable(cpu_write_enable), .cpu_data_out(cpu_data_out), .cpu_stall(cpu_stall),
    .io_memory_in(io_memory_in), .io_address(io_address), .io_write_enable(io_write_enable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: byte queue, console mode, and the cycle at which the next slot opens
  bit [7:0]  q[$];
  int        mst;
  longint    cycn;
  longint    next_slot;
  bit        exp_we;
  bit        exp_addr;
  bit [31:0] exp_data;
  bit [31:0] last_rd;

  // observed io pulses
  longint    obs_cyc[$];
  bit [31:0] obs_data[$];
  bit        obs_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    obs_cyc.delete(); obs_data.delete(); obs_addr.delete();
  endtask

  function automatic bit [31:0] model_read(input bit [1:0] a);
    bit [31:0] r = 32'h0;
    if (a == 2'd2)
      r = {16'b0, 8'(q.size()), 5'b0, mst == M_OFF, q.size() == DEPTH, q.size() == 0};
    return r;
  endfunction

  // One bus cycle: drive, check at negedge, advance the model across the next edge.
  task automatic cyc(input bit we, input bit [1:0] a, input bit [31:0] d, output bit stalled);
    int  pre;
    int  st_pre;
    bit  slot;
    cpu_write_enable = we; cpu_address = a; cpu_data_in = d;
    @(negedge clk);
    stalled = cpu_stall;
    last_rd = cpu_data_out;
    chk("stall", cpu_stall, (we && a == 2'd0 && mst == M_RUN && q.size() == DEPTH));
    chk("rdata", cpu_data_out, model_read(a));
    chk("io_we", io_write_enable, exp_we);
    chk("io_addr", io_address, exp_addr);
    chk("io_data", io_memory_in, exp_data);
    if (io_write_enable) begin
      obs_cyc.push_back(cycn); obs_data.push_back(io_memory_in); obs_addr.push_back(io_address);
    end
    pre = q.size(); st_pre = mst;
    slot = (cycn >= next_slot);
    exp_we = 1'b0;
    if (slot && pre > 0 && st_pre != M_OFF) begin
      exp_we = 1'b1; exp_addr = 1'b0; exp_data = {24'b0, q.pop_front()};
      next_slot = cycn + DIV;
    end else if (slot && pre == 0 && st_pre == M_DRAIN) begin
      exp_we = 1'b1; exp_addr = 1'b1; exp_data = 32'h0;
      mst = M_OFF; next_slot = cycn + DIV;
    end
    if (we && a == 2'd0 && st_pre == M_RUN && pre < DEPTH) q.push_back(d[7:0]);
    if (we && a == 2'd1 && st_pre == M_RUN) mst = M_DRAIN;
    cycn++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd2, 32'h0, s);
  endtask

  task automatic do_reset();
    cpu_write_enable = 1'b0; cpu_address = 2'd2;
    reset = 1'b1; #1;
    chk("rst_io_we", io_write_enable, 1'b0);
    chk("rst_io_addr", io_address, 1'b0);
    chk("rst_io_data", io_memory_in, 32'h0);
    chk("rst_status", cpu_data_out, 32'h1);
    chk("rst_stall", cpu_stall, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    q.delete(); mst = M_RUN; next_slot = 0;
    exp_we = 0; exp_addr = 0; exp_data = 0;
    clear_log();
  endtask

  initial begin
    bit        stl, stall_seen;
    longint    w;
    int        tries, npwr;
    bit [7:0]  sent[$];
    bit [7:0]  bv;
    int        r;
    cycn = 0;
    #2;
    do_reset();

    // single byte latency
    idle(2);
    w = cycn;
    cyc(1'b1, 2'd0, 32'hFFFF_FF41, stl);
    idle(6);
    chk("single_count", obs_data.size(), 1);
    if (obs_data.size() == 1) begin
      chk("single_data", obs_data[0], 32'h41);
      chk("single_cycle", 32'(obs_cyc[0] - w), 2);
      chk("single_addr", obs_addr[0], 1'b0);
    end

    // pacing of three back-to-back bytes
    clear_log();
    w = cycn;
    cyc(1'b1, 2'd0, 32'h48, stl);
    cyc(1'b1, 2'd0, 32'h69, stl);
    cyc(1'b1, 2'd0, 32'h0A, stl);
    idle(16);
    chk("pace_count", obs_data.size(), 3);
    if (obs_data.size() == 3) begin
      chk("pace_b0", obs_data[0], 32'h48);
      chk("pace_b1", obs_data[1], 32'h69);
      chk("pace_b2", obs_data[2], 32'h0A);
      chk("pace_first", 32'(obs_cyc[0] - w), 2);
      chk("pace_gap1", 32'(obs_cyc[1] - obs_cyc[0]), DIV);
      chk("pace_gap2", 32'(obs_cyc[2] - obs_cyc[1]), DIV);
    end

    // deferred power-off
    do_reset();
    cyc(1'b1, 2'd0, 32'h11, stl);
    cyc(1'b1, 2'd0, 32'h22, stl);
    cyc(1'b1, 2'd0, 32'h33, stl);
    cyc(1'b1, 2'd1, 32'hDEAD_BEEF, stl);
    cyc(1'b1, 2'd0, 32'h5A, stl);
    chk("defer_drop_stall", stl, 1'b0);
    idle(40);
    chk("defer_count", obs_data.size(), 4);
    if (obs_data.size() == 4) begin
      chk("defer_b0", obs_data[0], 32'h11);
      chk("defer_b1", obs_data[1], 32'h22);
      chk("defer_b2", obs_data[2], 32'h33);
      chk("defer_pwr_addr", obs_addr[3], 1'b1);
      chk("defer_pwr_data", obs_data[3], 32'h0);
      chk("defer_pwr_gap", 32'(obs_cyc[3] >= obs_cyc[2] + DIV), 1);
    end
    cyc(1'b0, 2'd2, 32'h0, stl);
    chk("defer_off_bit", last_rd[2], 1'b1);
    idle(50);
    chk("defer_quiet", obs_data.size(), 4);

    // reserved address and repeated POWER
    do_reset();
    cyc(1'b1, 2'd1, 32'h0, stl);
    cyc(1'b1, 2'd3, 32'h77, stl);
    chk("rsv_stall", stl, 1'b0);
    cyc(1'b1, 2'd1, 32'h0, stl);
    cyc(1'b0, 2'd3, 32'h0, stl);
    chk("rsv_read", last_rd, 32'h0);
    idle(20);
    npwr = 0;
    foreach (obs_addr[i]) if (obs_addr[i]) npwr++;
    chk("rsv_one_power", npwr, 1);
    chk("rsv_pulses", obs_data.size(), 1);

    // fill to full, hold stalled stores until accepted
    do_reset();
    sent.delete(); stall_seen = 0;
    for (int b = 0; b < 14; b++) begin
      bv = 8'(8'hA0 + b);
      tries = 0;
      do begin
        cyc(1'b1, 2'd0, {24'h0, bv}, stl);
        if (stl) stall_seen = 1;
        tries++;
      end while (stl && tries < 100);
      sent.push_back(bv);
    end
    idle(80);
    chk("full_stall_seen", stall_seen, 1'b1);
    chk("full_count", obs_data.size(), 14);
    if (obs_data.size() == 14)
      foreach (sent[i]) chk("full_order", obs_data[i], {24'h0, sent[i]});

    // reset in the middle of draining
    do_reset();
    for (int b = 0; b < 5; b++) cyc(1'b1, 2'd0, 32'(8'hC0 + b), stl);
    tries = 0;
    while (obs_data.size() < 2 && tries < 200) begin
      cyc(1'b0, 2'd2, 32'h0, stl);
      tries++;
    end
    chk("rstmid_two_pulses", (obs_data.size() >= 2), 1);
    do_reset();
    idle(20);
    chk("rstmid_quiet", obs_data.size(), 0);
    chk("rstmid_status", last_rd, 32'h1);
    cyc(1'b1, 2'd0, 32'h42, stl);
    idle(6);
    chk("rstmid_after", obs_data.size(), 1);
    if (obs_data.size() == 1) chk("rstmid_byte", obs_data[0], 32'h42);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      cyc(1'b1, 2'd0, $urandom, stl);
      else if (r < 52) cyc(1'b1, 2'd1, $urandom, stl);
      else if (r < 60) cyc(1'b1, 2'd3, $urandom, stl);
      else if (r < 75) cyc(1'b0, 2'd2, $urandom, stl);
      else             cyc(1'b0, 2'($urandom_range(0, 3)), $urandom, stl);
      if (mst == M_OFF && $urandom_range(0, 9) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
